periph_axi2apb_bridge: RTL
==========================

Name: periph_axi2apb_bridge

Overview:
AXI4 subordinate to APB manager bridge that sits directly upstream of the peripheral APB address decoder and drives its manager-side APB port. Converts AXI4 read/write transactions, including INCR bursts, into sequential 32-bit APB transfers, one transaction in flight at a time. Returns APB PREADY/PSLVERR results as AXI R/B responses. Enforces a PREADY timeout so a hung peripheral cannot stall the fabric.

Parameters:
APB_ADDR_WIDTH, 32, APB/AXI address width
APB_DATA_WIDTH, 32, data width; only 32 supported
AXI_ID_WIDTH, 4, AXI ID width
TIMEOUT_CYCLES, 255, max ACCESS-phase cycles before forced SLVERR; 0 disables timeout

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
awvalid_i / awready_o  in/out  1  AW handshake
awaddr_i  input  APB_ADDR_WIDTH  write start address
awid_i  input  AXI_ID_WIDTH  write ID
awlen_i  input  8  write beats minus 1
wvalid_i / wready_o  in/out  1  W handshake
wdata_i  input  APB_DATA_WIDTH  write data
wstrb_i  input  APB_DATA_WIDTH/8  write strobes
wlast_i  input  1  last write beat (not checked)
bvalid_o / bready_i  out/in  1  B handshake
bid_o  output  AXI_ID_WIDTH  write response ID
bresp_o  output  2  OKAY=00, SLVERR=10
arvalid_i / arready_o  in/out  1  AR handshake
araddr_i  input  APB_ADDR_WIDTH  read start address
arid_i  input  AXI_ID_WIDTH  read ID
arlen_i  input  8  read beats minus 1
rvalid_o / rready_i  out/in  1  R handshake
rdata_o  output  APB_DATA_WIDTH  read data
rid_o  output  AXI_ID_WIDTH  read ID
rresp_o  output  2  per-beat response
rlast_o  output  1  last read beat
psel_o, penable_o, pwrite_o  output  1  APB control
paddr_o  output  APB_ADDR_WIDTH  APB address
pwdata_o  output  APB_DATA_WIDTH  APB write data
pstrb_o  output  APB_DATA_WIDTH/8  APB strobes
prdata_i  input  APB_DATA_WIDTH  APB read data
pready_i  input  1  APB ready
psuberr_i  input  1  APB subordinate error

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0; beat counter, error flag, timeout counter and arbitration flag cleared. An in-flight APB transfer is abandoned; no response is issued.
- States: IDLE, WDATA, SETUP, ACCESS, RDATA, WRESP.
- IDLE: arready_o/awready_o combinationally asserted for the granted channel only. If both are valid, round-robin: the channel not served last wins; after reset, read wins. On handshake, latch address/ID/len, set beat=0, err=0, go to SETUP (read) or WDATA (write).
- WDATA: wready_o=1; on wvalid_i latch wdata/wstrb -> SETUP.
- SETUP: psel=1, penable=0, paddr={addr+4*beat}[W-1:2],2'b00 (wraps modulo 2^W), pwrite per direction, pstrb=wstrb for writes and 0 for reads -> ACCESS next cycle.
- ACCESS: psel=1, penable=1, with paddr/pwdata/pstrb/pwrite held stable. The timeout counter increments each cycle. Completion occurs on pready_i=1, or when the counter reaches TIMEOUT_CYCLES with pready_i low; a timeout counts as an error. On completion, psel/penable drop in the next cycle.
   - Read: capture prdata_i (0 on timeout); rresp=psuberr_i|timeout ? 10 : 00 -> RDATA.
   - Write: err |= psuberr_i|timeout; if beat==len -> WRESP, else beat++ -> WDATA.
- RDATA: rvalid_o=1, rid_o=latched ID, rlast_o=(beat==len), with data and response held. On rready_i: if last -> IDLE, else beat++ -> SETUP.
- WRESP: bvalid_o=1, bid_o=latched ID, bresp_o=err ? 10 : 00. On bready_i -> IDLE.
- Minimum latency from AR handshake at cycle 0 with zero-wait APB: psel cycle 1, penable cycle 2, rvalid cycle 3. Write: W accepted cycle 1, psel cycle 2, bvalid cycle 4.
- Error handling: SLVERR on one burst beat does not abort the burst; remaining beats are still performed. Decoder default-select returns PREADY=1/PSUBERR=1, which yields SLVERR.
- No new AR/AW is accepted until the current B or final R handshake completes.

Test Plan:
- Single read of 0x8f00_b000, prdata=0x1234_5678, zero-wait -> rvalid at cycle 3, rdata=0x12345678, rresp=00, rlast=1, rid echoed.
- Write of 0x8f00_0800 with data 0xA5A5_0001 and strb 0x3, with pready delayed 3 cycles -> penable held 4 cycles, pstrb=0x3, bresp=00, bvalid 1 cycle after pready.
- INCR read burst of 4 beats at 0x8f00_f7f8, with rready stalled 2 cycles on beat 1 -> paddr sequence f7f8, f7fc, f800, f804; no APB activity during the stall; rlast on beat 3 only.
- Write burst of 3 beats with psuberr on beat 2 -> all 3 APB writes occur; a single bresp=10.
- TIMEOUT_CYCLES=8, pready held low -> ACCESS lasts 8 cycles, then psel drops and rresp=10 with rdata=0.
- AR and AW asserted together after reset -> read served first, then write. rstn_i asserted mid-ACCESS -> psel_o=0 immediately and no response issued.

Source files
------------

// File: rtl/periph_axi2apb_bridge.sv
// AXI4 subordinate to APB manager bridge.
// Handles one AXI transaction at a time. An INCR burst becomes a sequence of
// 32-bit APB transfers. An ACCESS phase that is never completed by PREADY is
// ended by a timeout and reported as SLVERR.
module periph_axi2apb_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    // AXI write address
    input  logic                        awvalid_i,
    output logic                        awready_o,
    input  logic [APB_ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [AXI_ID_WIDTH-1:0]     awid_i,
    input  logic [7:0]                  awlen_i,
    // AXI write data
    input  logic                        wvalid_i,
    output logic                        wready_o,
    input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
    input  logic [APB_DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                        wlast_i,
    // AXI write response
    output logic                        bvalid_o,
    input  logic                        bready_i,
    output logic [AXI_ID_WIDTH-1:0]     bid_o,
    output logic [1:0]                  bresp_o,
    // AXI read address
    input  logic                        arvalid_i,
    output logic                        arready_o,
    input  logic [APB_ADDR_WIDTH-1:0]   araddr_i,
    input  logic [AXI_ID_WIDTH-1:0]     arid_i,
    input  logic [7:0]                  arlen_i,
    // AXI read data
    output logic                        rvalid_o,
    input  logic                        rready_i,
    output logic [APB_DATA_WIDTH-1:0]   rdata_o,
    output logic [AXI_ID_WIDTH-1:0]     rid_o,
    output logic [1:0]                  rresp_o,
    output logic                        rlast_o,
    // APB manager
    output logic                        psel_o,
    output logic                        penable_o,
    output logic                        pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
    output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
    output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
    input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
    input  logic                        pready_i,
    input  logic                        psuberr_i
);

    localparam int unsigned STRB_WIDTH = APB_DATA_WIDTH / 8;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_RDATA,
        S_WRESP
    } state_t;

    state_t state, state_nxt;

    logic                      is_write;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [7:0]                len_q;
    logic [7:0]                beat_q;
    logic                      err_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     wstrb_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;
    logic [31:0]               tmo_cnt_q;
    logic                      write_prio_q;   // 1: write wins the next AR/AW tie

    logic                      grant_rd, grant_wr;
    logic                      ar_hs, aw_hs;
    logic                      timeout_hit, access_done, xfer_err, last_beat;
    logic [APB_ADDR_WIDTH-1:0] beat_off, addr_sum;
    logic                      unused_ok;

    // Round-robin arbitration: on a tie, the channel not served last wins.
    assign grant_rd = arvalid_i && (!awvalid_i || !write_prio_q);
    assign grant_wr = awvalid_i && (!arvalid_i ||  write_prio_q);
    assign ar_hs    = (state == S_IDLE) && grant_rd;
    assign aw_hs    = (state == S_IDLE) && grant_wr;

    // The timeout ends ACCESS in its TIMEOUT_CYCLES-th cycle; PREADY in that
    // same cycle still completes the transfer normally.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pready_i &&
                         (tmo_cnt_q == TIMEOUT_CYCLES - 1);
    assign access_done = (state == S_ACCESS) && (pready_i || timeout_hit);
    assign xfer_err    = psuberr_i || timeout_hit;
    assign last_beat   = (beat_q == len_q);

    // Beat address wraps modulo 2^APB_ADDR_WIDTH and is forced word-aligned.
    assign beat_off = {{(APB_ADDR_WIDTH-10){1'b0}}, beat_q, 2'b00};
    assign addr_sum = addr_q + beat_off;

    // wlast_i is not checked: the burst length comes from AWLEN.
    assign unused_ok = ^{wlast_i, addr_sum[1:0]};

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        awready_o = 1'b0;
        arready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        bresp_o   = RESP_OKAY;
        rvalid_o  = 1'b0;
        rlast_o   = 1'b0;
        psel_o    = 1'b0;
        penable_o = 1'b0;
        pwrite_o  = 1'b0;
        pstrb_o   = '0;
        paddr_o   = {addr_sum[APB_ADDR_WIDTH-1:2], 2'b00};
        pwdata_o  = wdata_q;
        rdata_o   = rdata_q;
        rresp_o   = rresp_q;
        rid_o     = id_q;
        bid_o     = id_q;

        case (state)
            S_IDLE: begin
                arready_o = grant_rd;
                awready_o = grant_wr;
                if (ar_hs)      state_nxt = S_SETUP;
                else if (aw_hs) state_nxt = S_WDATA;
            end
            S_WDATA: begin
                wready_o = 1'b1;
                if (wvalid_i) state_nxt = S_SETUP;
            end
            S_SETUP: begin
                psel_o    = 1'b1;
                pwrite_o  = is_write;
                pstrb_o   = is_write ? wstrb_q : '0;
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                pwrite_o  = is_write;
                pstrb_o   = is_write ? wstrb_q : '0;
                if (access_done) begin
                    if (!is_write)     state_nxt = S_RDATA;
                    else if (last_beat) state_nxt = S_WRESP;
                    else               state_nxt = S_WDATA;
                end
            end
            S_RDATA: begin
                rvalid_o = 1'b1;
                rlast_o  = last_beat;
                if (rready_i) state_nxt = last_beat ? S_IDLE : S_SETUP;
            end
            S_WRESP: begin
                bvalid_o = 1'b1;
                bresp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (bready_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transaction context, beat counter, error flag, timeout counter and captured data.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: datapath registers are reset too, so every output reads 0 out of reset.
        if (!rstn_i) begin
            is_write     <= 1'b0;
            addr_q       <= '0;
            id_q         <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            tmo_cnt_q    <= '0;
            write_prio_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                is_write     <= 1'b0;
                addr_q       <= araddr_i;
                id_q         <= arid_i;
                len_q        <= arlen_i;
                beat_q       <= '0;
                err_q        <= 1'b0;
                write_prio_q <= 1'b1;
            end else if (aw_hs) begin
                is_write     <= 1'b1;
                addr_q       <= awaddr_i;
                id_q         <= awid_i;
                len_q        <= awlen_i;
                beat_q       <= '0;
                err_q        <= 1'b0;
                write_prio_q <= 1'b0;
            end

            if (state == S_WDATA && wvalid_i) begin
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end

            if (state == S_SETUP)
                tmo_cnt_q <= '0;
            else if (state == S_ACCESS && TIMEOUT_CYCLES != 0)
                tmo_cnt_q <= tmo_cnt_q + 32'd1;

            if (access_done) begin
                if (!is_write) begin
                    rdata_q <= timeout_hit ? '0 : prdata_i;
                    rresp_q <= xfer_err ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    err_q <= err_q | xfer_err;
                    if (!last_beat) beat_q <= beat_q + 8'd1;
                end
            end

            if (state == S_RDATA && rready_i && !last_beat)
                beat_q <= beat_q + 8'd1;
        end
    end

endmodule
